// File: rtl/reg_file_sb_if.sv
// Bus bundle for the two-read / two-write register file with busy scoreboard.
// The caller (decode, writeback and issue logic) drives the master side; the
// register file sits on the slave side. There is no valid/ready pair here:
// regWrite, regWrite2 and issueValid are single-cycle qualifiers that are
// always accepted at the next rising edge. Read data and busy flags are
// combinational and have no backpressure.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    // Read ports
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              busy1;
    logic              busy2;

    // Write port A (ALU writeback)
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic              regWrite;

    // Write port B (memory/load writeback)
    logic [ADDR_W-1:0] writeReg2;
    logic [DATA_W-1:0] writeData2;
    logic              regWrite2;

    // Issue port: marks a destination register as having a pending producer
    logic [ADDR_W-1:0] issueReg;
    logic              issueValid;

    modport master (
        output readReg1, readReg2,
        output writeReg, writeData, regWrite,
        output writeReg2, writeData2, regWrite2,
        output issueReg, issueValid,
        input  readData1, readData2, busy1, busy2
    );

    modport slave (
        input  readReg1, readReg2,
        input  writeReg, writeData, regWrite,
        input  writeReg2, writeData2, regWrite2,
        input  issueReg, issueValid,
        output readData1, readData2, busy1, busy2
    );
endinterface

// File: rtl/reg_file_sb.sv
// Two-write, two-read register file with write-to-read bypass and a
// per-register busy scoreboard for the pipelined MIPS datapath.
// Port A (ALU writeback) wins over port B (load writeback) on an address
// clash. An issue marking a register busy wins over a write clearing it in
// the same cycle, because the issue is the newer producer. With ZERO_REG set,
// register 0 reads as zero, drops writes and never becomes busy.
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input logic          clock,
    input logic          reset,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;

    // Architectural state
    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_next;

    // Filtered write strobes
    logic wr_a_en;
    logic wr_b_en;
    logic clr_b_en;

    // Per read port views (index 0 -> port 1, index 1 -> port 2)
    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];
    logic              hit_a   [2];
    logic              hit_b   [2];

    // True when the address is the hardwired zero register
    function automatic logic is_zero(input logic [ADDR_W-1:0] addr);
        return (ZERO_REG != 0) && (addr == ZERO_ADDR);
    endfunction

    // Qualify the write strobes: the zero register swallows writes and
    // port B loses to port A when both target the same word.
    always_comb begin
        wr_a_en  = bus.regWrite && !is_zero(bus.writeReg);
        clr_b_en = bus.regWrite2 && !is_zero(bus.writeReg2);
        wr_b_en  = clr_b_en &&
                   !(bus.regWrite && (bus.writeReg == bus.writeReg2));
    end

    assign rd_addr[0] = bus.readReg1;
    assign rd_addr[1] = bus.readReg2;

    // Combinational read with bypass: zero reg, then port A, then port B,
    // then stored word. Busy is masked by any write landing this cycle.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            hit_a[p]   = bus.regWrite  && (bus.writeReg  == rd_addr[p]);
            hit_b[p]   = bus.regWrite2 && (bus.writeReg2 == rd_addr[p]);
            rd_data[p] = regs[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]] && !hit_a[p] && !hit_b[p];
            if (is_zero(rd_addr[p])) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end else if (hit_a[p]) begin
                rd_data[p] = bus.writeData;
            end else if (hit_b[p]) begin
                rd_data[p] = bus.writeData2;
            end
        end
    end

    assign bus.readData1 = rd_data[0];
    assign bus.readData2 = rd_data[1];
    assign bus.busy1     = rd_busy[0];
    assign bus.busy2     = rd_busy[1];

    // Next scoreboard state: writes clear, then an issue sets (set wins).
    always_comb begin
        busy_next = busy;
        if (wr_a_en) begin
            busy_next[bus.writeReg] = 1'b0;
        end
        if (clr_b_en) begin
            busy_next[bus.writeReg2] = 1'b0;
        end
        if (bus.issueValid && !is_zero(bus.issueReg)) begin
            busy_next[bus.issueReg] = 1'b1;
        end
    end

    // Storage and scoreboard update; reset clears everything and overrides
    // any write or issue presented in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (wr_a_en) begin
                regs[bus.writeReg] <= bus.writeData;
            end
            if (wr_b_en) begin
                regs[bus.writeReg2] <= bus.writeData2;
            end
            busy <= busy_next;
        end
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: reset sweep, a table of directed vectors covering
// bypass, port priority, the zero register, scoreboard set/clear and a reset
// in mid-flight, followed by a randomised run checked against a small model.
module tb_reg_file_sb;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int W      = 2 * DATA_W + 2;

    // Clock/reset block
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    reg_file_sb_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    reg_file_sb #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(1)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic        rst;
        logic [4:0]  rr1;
        logic [4:0]  rr2;
        logic        wea;
        logic [4:0]  wa;
        logic [31:0] da;
        logic        web;
        logic [4:0]  wb;
        logic [31:0] db;
        logic        iv;
        logic [4:0]  iss;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
    } vec_t;

    vec_t        vecs[$];
    logic [W-1:0] exp_q[$];
    int          tests_run = 0;
    int          tests_failed = 0;

    // Reference model state for the random phase
    logic [31:0] m  [32];
    logic        mb [32];

    function automatic vec_t mk(
        input logic rst, input logic [4:0] rr1, input logic [4:0] rr2,
        input logic wea, input logic [4:0] wa, input logic [31:0] da,
        input logic web, input logic [4:0] wb, input logic [31:0] db,
        input logic iv, input logic [4:0] iss,
        input logic [31:0] e1, input logic [31:0] e2,
        input logic eb1, input logic eb2);
        vec_t v;
        v.rst = rst; v.rr1 = rr1; v.rr2 = rr2;
        v.wea = wea; v.wa = wa; v.da = da;
        v.web = web; v.wb = wb; v.db = db;
        v.iv = iv; v.iss = iss;
        v.e1 = e1; v.e2 = e2; v.eb1 = eb1; v.eb2 = eb2;
        return v;
    endfunction

    // Driver
    task automatic drive(input vec_t v);
        reset          = v.rst;
        bus.readReg1   = v.rr1;
        bus.readReg2   = v.rr2;
        bus.regWrite   = v.wea;
        bus.writeReg   = v.wa;
        bus.writeData  = v.da;
        bus.regWrite2  = v.web;
        bus.writeReg2  = v.wb;
        bus.writeData2 = v.db;
        bus.issueValid = v.iv;
        bus.issueReg   = v.iss;
    endtask

    // Scoreboard: pop the oldest expectation and compare the DUT outputs
    task automatic check_now(input string name, input int idx);
        logic [W-1:0] exp_v;
        logic [W-1:0] got_v;
        tests_run++;
        got_v = {bus.readData1, bus.readData2, bus.busy1, bus.busy2};
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL %s[%0d]: no expectation queued, got %h", name, idx, got_v);
        end else begin
            exp_v = exp_q.pop_front();
            if (got_v !== exp_v) begin
                tests_failed++;
                $display("FAIL %s[%0d]: got rd1=%h rd2=%h b1=%b b2=%b, expected rd1=%h rd2=%h b1=%b b2=%b",
                         name, idx, got_v[W-1:DATA_W+2], got_v[DATA_W+1:2], got_v[1], got_v[0],
                         exp_v[W-1:DATA_W+2], exp_v[DATA_W+1:2], exp_v[1], exp_v[0]);
            end
        end
    endtask

    // One clock cycle: drive after the edge, sample at the falling edge
    task automatic cycle(input vec_t v, input string name, input int idx, input bit chk);
        drive(v);
        if (chk) begin
            exp_q.push_back({v.e1, v.e2, v.eb1, v.eb2});
        end
        @(negedge clock);
        if (chk) begin
            check_now(name, idx);
        end
        @(posedge clock);
        #1;
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] a, input vec_t v);
        if (a == 5'd0) return 32'd0;
        if (v.wea && v.wa == a) return v.da;
        if (v.web && v.wb == a) return v.db;
        return m[a];
    endfunction

    function automatic logic model_busy(input logic [4:0] a, input vec_t v);
        return (a != 5'd0) && mb[a] && !(v.wea && v.wa == a) && !(v.web && v.wb == a);
    endfunction

    task automatic model_update(input vec_t v);
        if (v.rst) begin
            for (int i = 0; i < 32; i++) begin
                m[i]  = 32'd0;
                mb[i] = 1'b0;
            end
        end else begin
            if (v.web && v.wb != 5'd0 && !(v.wea && v.wa == v.wb)) m[v.wb] = v.db;
            if (v.wea && v.wa != 5'd0) m[v.wa] = v.da;
            if (v.wea && v.wa != 5'd0) mb[v.wa] = 1'b0;
            if (v.web && v.wb != 5'd0) mb[v.wb] = 1'b0;
            if (v.iv && v.iss != 5'd0) mb[v.iss] = 1'b1;
        end
    endtask

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;

        // Directed vectors: rst rr1 rr2 | wea wa da | web wb db | iv iss | e1 e2 eb1 eb2
        vecs.push_back(mk(0, 5, 6,  1, 5, 32'hDEADBEEF, 0, 0, 0,  0, 0,  32'hDEADBEEF, 0, 0, 0));
        vecs.push_back(mk(0, 5, 5,  0, 0, 0,            0, 0, 0,  0, 0,  32'hDEADBEEF, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 7, 7,  1, 7, 32'h11,       1, 7, 32'h22, 0, 0, 32'h11, 32'h11, 0, 0));
        vecs.push_back(mk(0, 7, 5,  0, 0, 0,            0, 0, 0,  0, 0,  32'h11, 32'hDEADBEEF, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,            1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0,            0, 0, 0,  0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 9, 9,  0, 0, 0,            0, 0, 0,  1, 9,  0, 0, 0, 0));
        vecs.push_back(mk(0, 9, 10, 0, 0, 0,            0, 0, 0,  0, 0,  0, 0, 1, 0));
        vecs.push_back(mk(0, 9, 9,  0, 0, 0,            1, 9, 32'hCAFE0009, 0, 0, 32'hCAFE0009, 32'hCAFE0009, 0, 0));
        vecs.push_back(mk(0, 9, 9,  0, 0, 0,            0, 0, 0,  0, 0,  32'hCAFE0009, 32'hCAFE0009, 0, 0));
        vecs.push_back(mk(0, 9, 9,  1, 9, 32'h99,       0, 0, 0,  1, 9,  32'h99, 32'h99, 0, 0));
        vecs.push_back(mk(0, 9, 9,  0, 0, 0,            0, 0, 0,  0, 0,  32'h99, 32'h99, 1, 1));
        vecs.push_back(mk(0, 9, 9,  0, 0, 0,            1, 9, 32'h1234, 0, 0, 32'h1234, 32'h1234, 0, 0));
        vecs.push_back(mk(0, 12, 13, 1, 12, 32'hA,      1, 13, 32'hB, 0, 0, 32'hA, 32'hB, 0, 0));
        vecs.push_back(mk(0, 5, 7,  0, 0, 0,            1, 5, 32'h5555, 0, 0, 32'h5555, 32'h11, 0, 0));
        vecs.push_back(mk(0, 5, 12, 0, 0, 0,            0, 0, 0,  0, 0,  32'h5555, 32'hA, 0, 0));
        // Reset in mid-flight
        vecs.push_back(mk(0, 3, 4,  1, 3, 32'h55,       0, 0, 0,  0, 0,  32'h55, 0, 0, 0));
        vecs.push_back(mk(0, 3, 4,  0, 0, 0,            0, 0, 0,  1, 3,  32'h55, 0, 0, 0));
        vecs.push_back(mk(0, 3, 4,  0, 0, 0,            0, 0, 0,  1, 4,  32'h55, 0, 1, 0));
        vecs.push_back(mk(0, 3, 4,  0, 0, 0,            0, 0, 0,  0, 0,  32'h55, 0, 1, 1));
        vecs.push_back(mk(1, 3, 4,  1, 4, 32'h77,       0, 0, 0,  0, 0,  32'h55, 32'h77, 1, 0));
        vecs.push_back(mk(0, 3, 4,  0, 0, 0,            0, 0, 0,  0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 5, 9,  0, 0, 0,            0, 0, 0,  0, 0,  0, 0, 0, 0));
        vecs.push_back(mk(0, 6, 0,  0, 0, 0,            1, 6, 32'h66, 0, 0, 32'h66, 0, 0, 0));

        // Initial reset (outputs undefined before it, so no check)
        cycle(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "reset", 0, 1'b0);

        // Reset sweep: every address reads zero and idle
        for (int i = 0; i < 32; i++) begin
            cycle(mk(0, 5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "sweep", i, 1'b1);
        end

        // Directed table
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i], "vec", i, 1'b1);
        end

        // Random phase against the model, starting from a fresh reset
        v = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle(v, "rand_reset", 0, 1'b0);
        model_update(v);
        for (int i = 0; i < 300; i++) begin
            v.rst = ($urandom_range(0, 49) == 0);
            v.rr1 = 5'($urandom_range(0, 7));
            v.rr2 = 5'($urandom_range(0, 7));
            v.wea = 1'($urandom_range(0, 1));
            v.wa  = 5'($urandom_range(0, 7));
            v.da  = $urandom;
            v.web = 1'($urandom_range(0, 1));
            v.wb  = 5'($urandom_range(0, 7));
            v.db  = $urandom;
            v.iv  = 1'($urandom_range(0, 1));
            v.iss = 5'($urandom_range(0, 7));
            v.e1  = model_read(v.rr1, v);
            v.e2  = model_read(v.rr2, v);
            v.eb1 = model_busy(v.rr1, v);
            v.eb2 = model_busy(v.rr2, v);
            cycle(v, "rand", i, 1'b1);
            model_update(v);
        end

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
